// File: rtl/gj_matrix_inverse_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gj_matrix_inverse_seq
// Purpose  : Sequential Gauss-Jordan inverter for an NxN signed fixed-point
//            matrix (Q(W-FRAC).FRAC) with partial pivoting and a singular flag.
//            The matrix is streamed in row-major over a valid/ready port. The
//            inverse is streamed out row-major over a second valid/ready port.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            in_valid   in_data valid
//            in_ready   element accepted (LOAD only)
//            in_data    matrix element, row-major
//            out_valid  out_data valid
//            out_ready  downstream accepts out_data
//            out_data   inverse element, row-major (all zero when singular)
//            busy       pivot search / swap / reciprocal / normalise / eliminate
//            singular   result flag, valid from first out_valid
// Revision : 1.0 - initial release
// ============================================================================
module gj_matrix_inverse_seq #(
  parameter int N    = 5,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         singular
);

  localparam int c_iw = (N > 1) ? $clog2(N) : 1;
  localparam int c_dw = W + FRAC;          // divider dividend/quotient width
  localparam int c_cw = $clog2(c_dw);

  localparam logic [c_iw-1:0] c_nm1 = c_iw'(N - 1);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_dw - 1);
  localparam logic [W-1:0] c_one = W'(1) << FRAC;
  localparam logic [c_dw-1:0] c_dividend = c_dw'(1) << (2 * FRAC);
  localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] c_pmax = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] c_pmin = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [2:0] c_st_load   = 3'd0;
  localparam logic [2:0] c_st_search = 3'd1;
  localparam logic [2:0] c_st_swap   = 3'd2;
  localparam logic [2:0] c_st_recip  = 3'd3;
  localparam logic [2:0] c_st_norm   = 3'd4;
  localparam logic [2:0] c_st_elim   = 3'd5;
  localparam logic [2:0] c_st_out    = 3'd6;

  // Fixed-point multiply: full-width product, floor shift, saturate.
  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = signed'({{W{a[W-1]}}, a}) * signed'({{W{b[W-1]}}, b});
    p = p >>> FRAC;
    if (p > c_pmax) return c_max;
    if (p < c_pmin) return c_min;
    return p[W-1:0];
  endfunction

  // Saturating signed subtract a - b.
  function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? c_min : c_max;
    return s[W-1:0];
  endfunction

  logic [2:0]      r_state, w_next;
  logic [W-1:0]    r_a [N][N];
  logic [W-1:0]    r_b [N][N];
  logic [c_iw-1:0] r_row, r_col;     // stream position in LOAD / OUT
  logic [c_iw-1:0] r_k, r_r, r_p;    // pivot column, scanned row, pivot row
  logic [W-1:0]    r_max;            // largest |A[r][k]| seen so far
  logic [W-1:0]    r_piv;            // signed value of the chosen pivot
  logic [W-1:0]    r_rem;
  logic [c_dw-1:0] r_quo;
  logic [c_cw-1:0] r_cnt;
  logic            r_singular;

  logic [W-1:0]    w_elem, w_mag, w_best_mag, w_div, w_diff, w_qsat, w_recip;
  logic [c_iw-1:0] w_best_p;
  logic [W:0]      w_trial;
  logic            w_take, w_ge, w_last_r, w_last_word, w_last_cnt;

  // Pivot search: a later row only wins on a strictly larger magnitude.
  assign w_elem      = r_a[r_r][r_k];
  assign w_mag       = w_elem[W-1] ? (~w_elem + W'(1)) : w_elem;
  assign w_take      = (r_r == r_k) || (w_mag > r_max);
  assign w_best_mag  = w_take ? w_mag : r_max;
  assign w_best_p    = w_take ? r_r : r_p;
  assign w_last_r    = (r_r == c_nm1);
  assign w_last_word = (r_row == c_nm1) && (r_col == c_nm1);
  assign w_last_cnt  = (r_cnt == c_cnt_last);

  // Restoring divider on the pivot magnitude; remainder always < divisor,
  // so the difference fits in W bits.
  assign w_div   = r_piv[W-1] ? (~r_piv + W'(1)) : r_piv;
  assign w_trial = {r_rem, r_quo[c_dw-1]};
  assign w_ge    = (w_trial >= {1'b0, w_div});
  assign w_diff  = w_trial[W-1:0] - w_div;
  // Quotient saturates before the pivot's sign is re-applied.
  assign w_qsat  = (|r_quo[c_dw-1:W-1]) ? c_max : r_quo[W-1:0];
  assign w_recip = r_piv[W-1] ? (~w_qsat + W'(1)) : w_qsat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_load;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_load:   if (in_valid && w_last_word) w_next = c_st_search;
      c_st_search: if (w_last_r) begin
                     if (w_best_mag == '0)    w_next = c_st_out;
                     else if (w_best_p == r_k) w_next = c_st_recip;
                     else                      w_next = c_st_swap;
                   end
      c_st_swap:   w_next = c_st_recip;
      c_st_recip:  if (w_last_cnt) w_next = c_st_norm;
      c_st_norm:   w_next = c_st_elim;
      c_st_elim:   if (w_last_r) w_next = (r_k == c_nm1) ? c_st_out : c_st_search;
      c_st_out:    if (out_ready && w_last_word) w_next = c_st_load;
      default:     w_next = c_st_load;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == c_st_load) && !rst;
    out_valid = (r_state == c_st_out) && !rst;
    busy      = (r_state == c_st_search) || (r_state == c_st_swap) ||
                (r_state == c_st_recip) || (r_state == c_st_norm) ||
                (r_state == c_st_elim);
    singular  = r_singular;
    out_data  = ((r_state == c_st_out) && !r_singular) ? r_b[r_row][r_col] : '0;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_r        <= '0;
      r_p        <= '0;
      r_max      <= '0;
      r_piv      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_singular <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= (i == j) ? c_one : '0;
        end
      end
    end else begin
      case (r_state)
        c_st_load: if (in_valid) begin
          r_a[r_row][r_col] <= in_data;
          if ((r_row == '0) && (r_col == '0)) r_singular <= 1'b0;
          if (r_col == c_nm1) begin
            r_col <= '0;
            r_row <= w_last_word ? '0 : r_row + c_iw'(1);
          end else begin
            r_col <= r_col + c_iw'(1);
          end
          if (w_last_word) begin
            r_k <= '0;
            r_r <= '0;
          end
        end
        c_st_search: begin
          if (w_take) begin
            r_max <= w_mag;
            r_p   <= r_r;
            r_piv <= w_elem;
          end
          r_rem <= '0;
          r_quo <= c_dividend;
          r_cnt <= '0;
          r_r   <= w_last_r ? '0 : r_r + c_iw'(1);
          if (w_last_r && (w_best_mag == '0)) r_singular <= 1'b1;
        end
        c_st_swap: begin
          for (int j = 0; j < N; j++) begin
            r_a[r_p][j] <= r_a[r_k][j];
            r_a[r_k][j] <= r_a[r_p][j];
            r_b[r_p][j] <= r_b[r_k][j];
            r_b[r_k][j] <= r_b[r_p][j];
          end
        end
        c_st_recip: begin
          r_rem <= w_ge ? w_diff : w_trial[W-1:0];
          r_quo <= {r_quo[c_dw-2:0], w_ge};
          r_cnt <= r_cnt + c_cw'(1);
        end
        c_st_norm: begin
          for (int j = 0; j < N; j++) begin
            r_a[r_k][j] <= f_mul(r_a[r_k][j], w_recip);
            r_b[r_k][j] <= f_mul(r_b[r_k][j], w_recip);
          end
        end
        c_st_elim: begin
          // Every column uses the pre-update factor A[r][k].
          if (r_r != r_k) begin
            for (int j = 0; j < N; j++) begin
              r_a[r_r][j] <= f_sub(r_a[r_r][j], f_mul(r_a[r_r][r_k], r_a[r_k][j]));
              r_b[r_r][j] <= f_sub(r_b[r_r][j], f_mul(r_a[r_r][r_k], r_b[r_k][j]));
            end
          end
          if (w_last_r) begin
            r_k <= r_k + c_iw'(1);
            r_r <= r_k + c_iw'(1);
          end else begin
            r_r <= r_r + c_iw'(1);
          end
        end
        c_st_out: if (out_ready) begin
          if (r_col == c_nm1) begin
            r_col <= '0;
            r_row <= w_last_word ? '0 : r_row + c_iw'(1);
          end else begin
            r_col <= r_col + c_iw'(1);
          end
          // Re-arm the augmented half as identity for the next matrix.
          if (w_last_word) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                r_b[i][j] <= (i == j) ? c_one : '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gj_matrix_inverse_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gj_matrix_inverse_seq
// Purpose  : Scoreboard bench for gj_matrix_inverse_seq (N=5 and N=2
//            instances). Stimulus pushes expected words; monitors compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gj_matrix_inverse_seq;

  localparam int W = 32;
  localparam int FRAC = 16;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  tol;
    logic         sing;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy, singular;
  logic [W-1:0] in_data, out_data;
  logic         in_valid_2, in_ready_2, out_valid_2, out_ready_2, busy_2, singular_2;
  logic [W-1:0] in_data_2, out_data_2;

  gj_matrix_inverse_seq #(.N(5), .W(W), .FRAC(FRAC)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .singular(singular)
  );

  gj_matrix_inverse_seq #(.N(2), .W(W), .FRAC(FRAC)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_2), .in_ready(in_ready_2), .in_data(in_data_2),
    .out_valid(out_valid_2), .out_ready(out_ready_2), .out_data(out_data_2),
    .busy(busy_2), .singular(singular_2)
  );

  int checks = 0;
  int errors = 0;
  exp_t q5[$];
  exp_t q2[$];
  logic [W-1:0] mat_in [25];
  logic [W-1:0] mat_exp[25];
  bit rand_ready = 1'b0;

  function automatic logic [W-1:0] qv(input int v);
    return W'(v * 65536);
  endfunction

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  task automatic cmp_word(input string tag, input int idx, input logic [W-1:0] got,
                          input logic sing, input exp_t e);
    longint d;
    d = longint'($signed(got)) - longint'($signed(e.data));
    if (d < 0) d = -d;
    checks++;
    if (d > longint'(e.tol) || sing !== e.sing) begin
      errors++;
      $display("FAIL %s word %0d got %h singular %b expected %h (+/-%0d) singular %b",
               tag, idx, got, sing, e.data, e.tol, e.sing);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 25; i++) begin
      mat_in[i]  = '0;
      mat_exp[i] = '0;
    end
  endtask

  task automatic push_exp(input bit sel, input int n, input int unsigned tol, input bit sing);
    exp_t e;
    for (int i = 0; i < n * n; i++) begin
      e.data = sing ? '0 : mat_exp[i];
      e.tol  = tol;
      e.sing = sing;
      if (sel) q2.push_back(e);
      else     q5.push_back(e);
    end
  endtask

  task automatic wait_accept(input bit sel);
    bit hs;
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      hs = sel ? in_ready_2 : in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      t++;
      if (t > 5000) begin
        checks++;
        errors++;
        $display("FAIL in_handshake_timeout waited %0d cycles, in_ready=1 required", t);
        finish_run();
      end
    end
  endtask

  task automatic load_mat(input bit sel, input int n, input bit gaps);
    for (int i = 0; i < n * n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (sel) begin in_valid_2 = 1'b1; in_data_2 = mat_in[i]; end
      else     begin in_valid   = 1'b1; in_data   = mat_in[i]; end
      wait_accept(sel);
    end
    in_valid   = 1'b0;
    in_valid_2 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q5.size() != 0 || q2.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (q5.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d/%0d words, 0 required", q5.size(), q2.size());
      finish_run();
    end
    #1;
  endtask

  task automatic set_identity();
    clear_mats();
    for (int i = 0; i < 5; i++) begin
      mat_in[i*5+i]  = qv(1);
      mat_exp[i*5+i] = qv(1);
    end
  endtask

  task automatic set_t2();
    clear_mats();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        mat_in[i*5+j] = qv((i == j && i > 0) ? i + 2 : i + 1);
        if (i == 0)      mat_exp[j]     = qv(j == 0 ? 15 : -1);
        else if (j == 0) mat_exp[i*5]   = qv(-(i + 1));
        else if (j == i) mat_exp[i*5+j] = qv(1);
      end
    end
  endtask

  // out_ready drivers, updated just after each active edge
  initial begin
    out_ready   = 1'b1;
    out_ready_2 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the N=5 instance, including stall stability
  int           mon5_idx = 0;
  bit           stall_pend = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (stall_pend) chk("stall_stable", out_data, held);
      if (out_ready) begin
        stall_pend = 1'b0;
        if (q5.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out5 got %h, no word expected", out_data);
        end else begin
          e = q5.pop_front();
          cmp_word("out5", mon5_idx, out_data, singular, e);
        end
        mon5_idx++;
      end else begin
        stall_pend = 1'b1;
        held = out_data;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Monitor for the N=2 instance
  int mon2_idx = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_2 && out_ready_2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out2 got %h, no word expected", out_data_2);
      end else begin
        e = q2.pop_front();
        cmp_word("out2", mon2_idx, out_data_2, singular_2, e);
      end
      mon2_idx++;
    end
  end

  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL global_timeout simulation did not complete");
    finish_run();
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_valid_2 = 1'b0;
    in_data_2  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_singular", W'(singular), '0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Identity in, identity out
    set_identity();
    push_exp(1'b0, 5, 0, 1'b0);
    load_mat(1'b0, 5, 1'b0);
    drain();

    // Integer matrix with a known integer inverse (pivot swaps occur)
    set_t2();
    push_exp(1'b0, 5, 32'h400, 1'b0);
    load_mat(1'b0, 5, 1'b0);
    drain();

    // Diagonal with exact power-of-two reciprocals
    clear_mats();
    for (int i = 0; i < 5; i++) begin
      mat_in[i*5+i]  = qv((i % 2 == 0) ? 2 : 4);
      mat_exp[i*5+i] = (i % 2 == 0) ? 32'h0000_8000 : 32'h0000_4000;
    end
    push_exp(1'b0, 5, 0, 1'b0);
    load_mat(1'b0, 5, 1'b0);
    drain();

    // All-ones: singular, 25 zero words
    clear_mats();
    for (int i = 0; i < 25; i++) mat_in[i] = qv(1);
    push_exp(1'b0, 5, 0, 1'b1);
    load_mat(1'b0, 5, 1'b0);
    drain();

    // Backpressure and input gaps on the integer matrix
    set_t2();
    rand_ready = 1'b1;
    push_exp(1'b0, 5, 32'h400, 1'b0);
    load_mat(1'b0, 5, 1'b1);
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // 2x2 permutation: forces a pivot swap
    clear_mats();
    mat_in[1] = qv(1);  mat_in[2] = qv(1);
    mat_exp[1] = qv(1); mat_exp[2] = qv(1);
    push_exp(1'b1, 2, 0, 1'b0);
    load_mat(1'b1, 2, 1'b0);
    drain();

    // Reset during the k=2 elimination pass, then a clean reload
    set_identity();
    load_mat(1'b0, 5, 1'b0);
    repeat (170) @(posedge clk);
    #1;
    chk("busy_before_reset", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", W'(in_ready), '0);
    chk("abort_out_valid", W'(out_valid), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_singular", W'(singular), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rel_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    push_exp(1'b0, 5, 0, 1'b0);
    load_mat(1'b0, 5, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    finish_run();
  end

endmodule
`default_nettype wire
